// File: rtl/arb7_pkg.sv
// Shared definitions for the 7-requester round-robin scheduler.
//   NUM_REQ : number of requesters feeding the shared 7:1 mux
//   SEL_W   : width of the mux select / requester index
//   state_t : scheduler FSM states
package arb7_pkg;

  localparam int NUM_REQ = 7;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick7.sv
// Combinational round-robin picker for 7 requesters.
// Searches start+1, start+2, ... modulo 7; the start index itself is tried
// last, so a lone requester sitting on the start index is still found.
//   req   [6:0] : request vector
//   start [2:0] : last-served index (0..6)
//   found       : some request bit is set
//   idx   [2:0] : first requester found (0..6), 0 when none
module rr_pick7
  import arb7_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest
  // hit is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = SEL_W'((int'(start) + i) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arb7_rr_sched.sv
// Round-robin scheduler driving the select of a shared 7:1 mux.
// A grant is held while the owner keeps its request high; when it drops,
// the next requester (searching past the old owner) is granted on the same
// edge with no idle gap. All outputs are registered.
// Optional feature: define ARB7_RR_SCHED_TIMEOUT_EN to compile in a hold
// counter that forcibly revokes a grant after MAX_HOLD cycles and pulses
// timeout for one cycle.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   req [6:0] : per-requester request
//   gnt [6:0] : one-hot grant, zero when idle
//   sel [2:0] : index of the granted requester, keeps last value when idle
//   sel_valid : a grant is active
//   timeout   : one-cycle pulse on forced revocation
module arb7_rr_sched
  import arb7_pkg::*;
#(
  parameter int MAX_HOLD = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               timeout
);

  state_t               state_q, state_nxt;
  logic [SEL_W-1:0]     ptr_q, ptr_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic                 sel_valid_nxt;
  logic                 timeout_nxt;
  logic                 new_grant;
  logic                 release_gnt;
  logic                 forced;
  logic                 move;
  logic [SEL_W-1:0]     pick_start;
  logic                 pick_found;
  logic [SEL_W-1:0]     pick_idx;

  // While busy the search starts just past the current owner, which is
  // also the value the pointer takes on the handover edge.
  assign pick_start = (state_q == BUSY) ? sel : ptr_q;

  rr_pick7 u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign release_gnt = (state_q == BUSY) && !req[sel];

`ifdef ARB7_RR_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_inc;

  // The first busy cycle is count 0, so the owner sees MAX_HOLD cycles of
  // grant before the revoking edge.
  assign hold_cnt_inc = hold_cnt_q + CNT_W'(1);
  assign forced = (state_q == BUSY) && req[sel] && (hold_cnt_inc == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (!rst_n)
      hold_cnt_q <= '0;
    else if (new_grant)
      hold_cnt_q <= '0;
    else if (state_q == BUSY)
      hold_cnt_q <= hold_cnt_inc;
  end
`else
  logic [31:0] unused_max_hold;

  assign unused_max_hold = 32'(MAX_HOLD);
  assign forced = 1'b0;
`endif

  assign move = release_gnt || forced;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_nxt = BUSY;
      BUSY:    if (move && !pick_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the round-robin pointer
  always_comb begin
    gnt_nxt       = gnt;
    sel_nxt       = sel;
    sel_valid_nxt = sel_valid;
    timeout_nxt   = 1'b0;
    ptr_nxt       = ptr_q;
    new_grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_nxt       = NUM_REQ'(1) << pick_idx;
          sel_nxt       = pick_idx;
          sel_valid_nxt = 1'b1;
          new_grant     = 1'b1;
        end
      end
      BUSY: begin
        if (move) begin
          ptr_nxt     = sel;
          timeout_nxt = forced;
          if (pick_found) begin
            gnt_nxt       = NUM_REQ'(1) << pick_idx;
            sel_nxt       = pick_idx;
            sel_valid_nxt = 1'b1;
            new_grant     = 1'b1;
          end else begin
            gnt_nxt       = '0;
            sel_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        gnt_nxt       = '0;
        sel_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr_q     <= SEL_W'(NUM_REQ - 1);
    end else begin
      gnt       <= gnt_nxt;
      sel       <= sel_nxt;
      sel_valid <= sel_valid_nxt;
      timeout   <= timeout_nxt;
      ptr_q     <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_arb7_rr_sched.sv
// Self-checking bench for arb7_rr_sched. Expected output tuples are queued
// when a cycle's stimulus is applied and compared after the following edge.
module tb_arb7_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] req = '0;
  logic [6:0] gnt;
  logic [2:0] sel;
  logic       sel_valid;
  logic       timeout;

  arb7_rr_sched #(.MAX_HOLD(30)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] gnt;
    logic [2:0] sel;
    logic       sv;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input logic [6:0] g, input logic [2:0] s, input logic v, input logic t);
    exp_t e;
    e.gnt = g; e.sel = s; e.sv = v; e.to = t;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0;
    req   = 7'h7F;
    push(7'h00, 3'd0, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    n_tests++;
    if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
      n_fail++;
      $display("FAIL reset: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
               gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
    end
    req   = '0;
    rst_n = 1'b1;
  endtask

  // Single requester: 1-cycle latency, hold, release to idle with sel kept.
  task automatic test_single;
    exp_t       e;
    logic [6:0] rq [4] = '{7'h01, 7'h01, 7'h01, 7'h00};
    logic [6:0] eg [4] = '{7'h01, 7'h01, 7'h01, 7'h00};
    logic       ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      req = rq[i];
      push(eg[i], 3'd0, ev[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
        n_fail++;
        $display("FAIL single[%0d]: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
                 i, gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
      end
    end
  endtask

  // All requesting; each owner drops one cycle after its grant.
  task automatic test_back_to_back;
    exp_t e;
    int   s;
    test_reset();
    req = 7'h7F;
    push(7'h01, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
                 k, gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
      end
      if (k <= 7) begin
        req = 7'h7F & ~(7'd1 << ((k - 1) % 7));
        s   = k % 7;
        push(7'd1 << s, 3'(s), 1'b1, 1'b0);
      end else begin
        req = '0;
        push(7'h00, 3'd0, 1'b0, 1'b0);
      end
    end
    tick();
    e = sb.pop_front();
    n_tests++;
    if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
      n_fail++;
      $display("FAIL b2b_idle: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
               gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
    end
  endtask

  // Wrap-around, sel retention in idle, no preemption, drop-and-raise.
  task automatic test_wrap;
    exp_t       e;
    logic [6:0] rq [9] = '{7'h40, 7'h04, 7'h00, 7'h04, 7'h0E, 7'h0A, 7'h02, 7'h20, 7'h00};
    logic [6:0] eg [9] = '{7'h40, 7'h04, 7'h00, 7'h04, 7'h04, 7'h08, 7'h02, 7'h20, 7'h00};
    logic [2:0] es [9] = '{3'd6, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd1, 3'd5, 3'd5};
    logic       ev [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    test_reset();
    for (int i = 0; i < 9; i++) begin
      req = rq[i];
      push(eg[i], es[i], ev[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
                 i, gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
      end
    end
  endtask

  // Requesters 3 and 5 held continuously.
  task automatic test_timeout;
    exp_t e;
    int   n;
    test_reset();
    req = 7'h28;
`ifdef ARB7_RR_SCHED_TIMEOUT_EN
    for (int i = 0; i < 30; i++) push(7'h08, 3'd3, 1'b1, 1'b0);
    push(7'h20, 3'd5, 1'b1, 1'b1);
    push(7'h20, 3'd5, 1'b1, 1'b0);
    n = 32;
`else
    for (int i = 0; i < 40; i++) push(7'h08, 3'd3, 1'b1, 1'b0);
    n = 40;
`endif
    for (int i = 0; i < n; i++) begin
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
                 i, gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
      end
    end
`ifdef ARB7_RR_SCHED_TIMEOUT_EN
    // Lone requester times out and is re-granted with a pulse.
    req = 7'h08;
    for (int i = 0; i < 30; i++) push(7'h08, 3'd3, 1'b1, 1'b0);
    push(7'h08, 3'd3, 1'b1, 1'b1);
    push(7'h08, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
        n_fail++;
        $display("FAIL regrant[%0d]: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
                 i, gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
      end
    end
`endif
    req = '0;
    tick();
  endtask

  // Reset pulse while requester 4 holds the grant.
  task automatic test_reset_mid_busy;
    exp_t       e;
    logic       rn [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0] rq [5] = '{7'h10, 7'h10, 7'h10, 7'h10, 7'h00};
    logic [6:0] eg [5] = '{7'h10, 7'h10, 7'h00, 7'h10, 7'h00};
    logic [2:0] es [5] = '{3'd4, 3'd4, 3'd0, 3'd4, 3'd4};
    logic       ev [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      rst_n = rn[i];
      req   = rq[i];
      push(eg[i], es[i], ev[i], 1'b0);
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({gnt, sel, sel_valid, timeout} !== {e.gnt, e.sel, e.sv, e.to}) begin
        n_fail++;
        $display("FAIL rst_busy[%0d]: got gnt=%b sel=%0d v=%b to=%b, want gnt=%b sel=%0d v=%b to=%b",
                 i, gnt, sel, sel_valid, timeout, e.gnt, e.sel, e.sv, e.to);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_reset_mid_busy();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb7_rr_sched.md
ARB7_RR_SCHED -- requirements
Module: arb7_rr_sched

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 30, maximum cycles one requester may hold the grant (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port req  input  7  per-requester request; bit i = data input i of the shared 7:1 mux.
REQ-005 The block SHALL have port gnt  output  7  one-hot grant, all-zero when idle.
REQ-006 The block SHALL have port sel  output  3  mux select, equal to the index of the set gnt bit; values 0..6 only.
REQ-007 The block SHALL have port sel_valid  output  1  high while any gnt bit is set.
REQ-008 The block SHALL have port timeout  output  1  one-cycle pulse on forced grant revocation.

Function
REQ-009 The block SHALL implement states IDLE and BUSY; all outputs registered.
REQ-010 IDLE with req != 0 SHALL grant on the next edge: enter BUSY, gnt/sel = first requester searching ptr+1, ptr+2, ... modulo 7.
REQ-011 Request-to-grant latency SHALL be exactly 1 cycle from IDLE.
REQ-012 In BUSY the grant SHALL hold while req[sel] stays high; requester drops req to release.
REQ-013 When req[sel] is low in BUSY, ptr SHALL load sel and, on the same edge, the next requester (search from sel+1, mod 7) SHALL be granted back-to-back; if none, go IDLE with gnt=0, sel_valid=0.
REQ-014 sel SHALL retain its last granted value while IDLE.
REQ-015 Search wrap-around SHALL go 6 -> 0; value 7 SHALL never appear on sel.
REQ-016 New requests arriving while BUSY SHALL not preempt the current grant.
REQ-017 A requester dropping req in the same cycle others raise req SHALL be treated per REQ-013 using the current-cycle req vector.

Reset
REQ-018 On rst_n low at a rising edge: state=IDLE, gnt=0, sel=0, sel_valid=0, timeout=0, ptr=6 (first search starts at index 0), hold counter=0.
REQ-019 Reset asserted mid-BUSY SHALL drop the grant on that edge; no timeout pulse.

Configuration
REQ-020 Macro ARB7_RR_SCHED_TIMEOUT_EN SHALL compile in the hold counter and forced revocation.
REQ-021 With the macro: counter of width $clog2(MAX_HOLD+1) clears on each new grant and increments each BUSY cycle; when it reaches MAX_HOLD with req[sel] still high, the grant SHALL move per REQ-013 search and timeout SHALL pulse for 1 cycle.
REQ-022 With the macro, if the timed-out requester is the only one requesting, it SHALL be re-granted (same sel), counter cleared, timeout still pulsed.
REQ-023 Without the macro: no counter, timeout tied 0, grant held indefinitely.

Structure
REQ-024 Package arb7_pkg SHALL hold NUM_REQ=7, SEL_W=3, and the state enum (IDLE, BUSY).
REQ-025 Combinational sub-module rr_pick7 SHALL take req and start pointer, return found flag and 3-bit index; instantiated once.

Verification
REQ-026 Reset then req=7'b0000001 -> after 1 cycle gnt=7'b0000001, sel=0, sel_valid=1.
REQ-027 req=7'b1111111 held, each holder drops 1 cycle after grant -> sel sequence 0,1,2,3,4,5,6,0 with no idle gap.
REQ-028 sel=6 granted, req[6] drops, req=7'b0000100 -> next sel=2 (wrap through 0,1).
REQ-029 TIMEOUT_EN, MAX_HOLD=30, req[3] and req[5] held high -> sel=3 for 30 cycles, timeout pulse, sel=5; without macro sel stays 3, timeout always 0.
REQ-030 rst_n low for 1 cycle during BUSY at sel=4 -> next cycle gnt=0, sel=0, sel_valid=0; with req[4] still high, re-grant sel=4 one cycle after rst_n high.
